// File: rtl/rgb_pattern_controller_pkg.sv
// Shared types and colour table for the RGB pattern sequencer.
// Provides mode_t, SEQ_LEN, COLOR_TABLE, next_index() and next_mode().
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    MANUAL = 2'd1,
    AUTO   = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  localparam int SEQ_LEN = 6;

  // Element 0 is the rightmost entry: R Y G C B M
  localparam logic [SEQ_LEN-1:0][2:0] COLOR_TABLE = {
    3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001
  };

  function automatic logic [2:0] next_index(
    input logic [2:0] idx
  );
    return (idx == 3'(SEQ_LEN - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  function automatic mode_t next_mode(
    input mode_t m
  );
    mode_t r;
    unique case (m)
      OFF:     r = MANUAL;
      MANUAL:  r = AUTO;
      AUTO:    r = BLINK;
      default: r = OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rgb_pattern_controller_if.sv
// Pulse inputs and registered LED/status outputs of the sequencer.
// master: pulse source / observer; slave: the controller.
interface rgb_pattern_controller_if;

  logic       step_pulse;
  logic       mode_pulse;
  logic [2:0] rgb;
  logic [1:0] mode_out;
  logic [2:0] index_out;

  modport master (
    output step_pulse,
    output mode_pulse,
    input  rgb,
    input  mode_out,
    input  index_out
  );

  modport slave (
    input  step_pulse,
    input  mode_pulse,
    output rgb,
    output mode_out,
    output index_out
  );

endinterface

// File: rtl/rgb_pattern_controller_tick_timer.sv
// Free-running tick counter wrapping at a runtime last-count value.
// Ports: clk, rst (sync, active-low), clear, enable, last, terminal.
module tick_timer #(
  parameter int MAX = 12_000_000,
  localparam int W  = (MAX > 2) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] last,
  output logic         terminal
);

  logic [W-1:0] cnt;

  assign terminal = enable && (cnt == last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || terminal) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_pattern_controller.sv
// Mode-driven RGB LED sequencer: OFF, MANUAL step, AUTO advance, BLINK.
// Ports: clk, rst (sync, active-low), bus (slave: pulses in, rgb/mode/index out).
module rgb_pattern_controller
  import rgb_seq_pkg::*;
#(
  parameter int  PERIOD_TICKS = 12_000_000,
  localparam int CNT_W = (PERIOD_TICKS > 2) ? $clog2(PERIOD_TICKS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  rgb_pattern_controller_if.slave  bus
);

  if (PERIOD_TICKS < 2 || (PERIOD_TICKS % 2) != 0) begin : g_bad_period
    $error("PERIOD_TICKS must be even and >= 2");
  end

  mode_t      mode_q, mode_d;
  logic [2:0] index_q, index_d;
  logic       phase_q, phase_d;

  logic             tmr_clear;
  logic             tmr_en;
  logic             tmr_term;
  logic [CNT_W-1:0] tmr_last;

  logic [2:0] rgb_q;
  logic [1:0] mode_oq;
  logic [2:0] index_oq;

  assign tmr_en = (mode_q == AUTO) || (mode_q == BLINK);

  // BLINK toggles every half period so a full on/off cycle is one period
  assign tmr_last = (mode_q == BLINK)
                  ? CNT_W'(PERIOD_TICKS / 2 - 1)
                  : CNT_W'(PERIOD_TICKS - 1);

  tick_timer #(
    .MAX (PERIOD_TICKS)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .enable   (tmr_en),
    .last     (tmr_last),
    .terminal (tmr_term)
  );

  // mode_pulse > step_pulse > terminal; a step that lands on the
  // terminal count wins and the terminal advance is swallowed
  always_comb begin
    mode_d    = mode_q;
    index_d   = index_q;
    phase_d   = phase_q;
    tmr_clear = !tmr_en;
    if (bus.mode_pulse) begin
      mode_d    = next_mode(mode_q);
      phase_d   = 1'b1;
      tmr_clear = 1'b1;
    end else if (bus.step_pulse && mode_q != OFF) begin
      index_d   = next_index(index_q);
      phase_d   = 1'b1;
      tmr_clear = 1'b1;
    end else if (tmr_term) begin
      if (mode_q == AUTO) begin
        index_d = next_index(index_q);
      end else begin
        phase_d = !phase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q  <= OFF;
      index_q <= 3'd0;
      phase_q <= 1'b1;
    end else begin
      mode_q  <= mode_d;
      index_q <= index_d;
      phase_q <= phase_d;
    end
  end

  logic lit;

  always_comb begin
    lit = 1'b0;
    unique case (mode_q)
      MANUAL:  lit = 1'b1;
      AUTO:    lit = 1'b1;
      BLINK:   lit = phase_q;
      default: lit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb_q    <= 3'b000;
      mode_oq  <= OFF;
      index_oq <= 3'd0;
    end else begin
      rgb_q    <= lit ? COLOR_TABLE[index_q] : 3'b000;
      mode_oq  <= mode_q;
      index_oq <= index_q;
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.mode_out  = mode_oq;
  assign bus.index_out = index_oq;

endmodule

// File: tb/tb_rgb_pattern_controller.sv
// Directed bench for rgb_pattern_controller with PERIOD_TICKS=8.
// Inputs change and outputs are sampled 1ns after each posedge.
module tb_rgb_pattern_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int errs   = 0;
  int checks = 0;

  rgb_pattern_controller_if bus ();

  rgb_pattern_controller #(
    .PERIOD_TICKS (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [2:0] man_rgb [7];
  logic [2:0] man_idx [7];
  logic [2:0] blk_exp;

  initial begin
    man_rgb = '{3'b011, 3'b010, 3'b110, 3'b100,
                3'b101, 3'b001, 3'b011};
    man_idx = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    bus.step_pulse = 1'b0;
    bus.mode_pulse = 1'b0;

    // reset and mode walk
    cyc(2);
    chk("rst_rgb", 8'(bus.rgb), 8'h0);
    chk("rst_mode", 8'(bus.mode_out), 8'h0);
    chk("rst_idx", 8'(bus.index_out), 8'h0);
    rst = 1'b1;
    for (int m = 1; m <= 3; m++) begin
      bus.mode_pulse = 1'b1;
      cyc(1);
      bus.mode_pulse = 1'b0;
      chk($sformatf("mode_lag%0d", m), 8'(bus.mode_out), 8'(m - 1));
      cyc(1);
      chk($sformatf("mode%0d", m), 8'(bus.mode_out), 8'(m));
    end
    bus.mode_pulse = 1'b1;
    cyc(1);
    bus.mode_pulse = 1'b0;
    cyc(1);
    chk("mode_wrap", 8'(bus.mode_out), 8'h0);
    bus.mode_pulse = 1'b1;
    cyc(1);
    bus.mode_pulse = 1'b0;
    cyc(1);
    chk("man_mode", 8'(bus.mode_out), 8'h1);
    chk("man_rgb0", 8'(bus.rgb), 8'h1);

    // manual stepping with wrap
    for (int i = 0; i < 7; i++) begin
      bus.step_pulse = 1'b1;
      cyc(1);
      bus.step_pulse = 1'b0;
      cyc(1);
      chk($sformatf("man_rgb%0d", i + 1), 8'(bus.rgb), 8'(man_rgb[i]));
      chk($sformatf("man_idx%0d", i + 1), 8'(bus.index_out),
          8'(man_idx[i]));
      cyc(1);
    end
    // held-high step advances once per cycle: 1 + 5 -> 0
    bus.step_pulse = 1'b1;
    cyc(5);
    bus.step_pulse = 1'b0;
    cyc(1);
    chk("held_idx", 8'(bus.index_out), 8'h0);
    chk("held_rgb", 8'(bus.rgb), 8'h1);

    // simultaneous pulses: mode wins, step dropped (enters AUTO at 0)
    bus.mode_pulse = 1'b1;
    bus.step_pulse = 1'b1;
    cyc(1);
    bus.mode_pulse = 1'b0;
    bus.step_pulse = 1'b0;
    cyc(1);
    chk("sim_mode", 8'(bus.mode_out), 8'h2);
    chk("sim_idx", 8'(bus.index_out), 8'h0);
    chk("auto_rgb", 8'(bus.rgb), 8'h1);

    // auto timing
    cyc(7);
    chk("auto_pre1", 8'(bus.index_out), 8'h0);
    cyc(1);
    chk("auto_adv1", 8'(bus.index_out), 8'h1);
    cyc(7);
    chk("auto_pre2", 8'(bus.index_out), 8'h1);
    cyc(1);
    chk("auto_adv2", 8'(bus.index_out), 8'h2);
    cyc(4);
    bus.step_pulse = 1'b1;
    cyc(1);
    bus.step_pulse = 1'b0;
    cyc(1);
    chk("auto_step", 8'(bus.index_out), 8'h3);
    cyc(7);
    chk("auto_pre3", 8'(bus.index_out), 8'h3);
    cyc(1);
    chk("auto_adv3", 8'(bus.index_out), 8'h4);

    // step coincident with terminal count
    cyc(6);
    bus.step_pulse = 1'b1;
    cyc(1);
    bus.step_pulse = 1'b0;
    cyc(1);
    chk("term_step", 8'(bus.index_out), 8'h5);
    cyc(7);
    chk("term_pre", 8'(bus.index_out), 8'h5);
    cyc(1);
    chk("term_adv", 8'(bus.index_out), 8'h0);

    // blink at index 2
    bus.step_pulse = 1'b1;
    cyc(2);
    bus.step_pulse = 1'b0;
    bus.mode_pulse = 1'b1;
    cyc(1);
    bus.mode_pulse = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      blk_exp = (k <= 4 || k >= 9) ? 3'b010 : 3'b000;
      chk($sformatf("blink%0d", k), 8'(bus.rgb), 8'(blk_exp));
    end
    cyc(1);
    chk("blk_off", 8'(bus.rgb), 8'h0);
    bus.step_pulse = 1'b1;
    cyc(1);
    bus.step_pulse = 1'b0;
    chk("blk_step_lag", 8'(bus.rgb), 8'h0);
    cyc(1);
    chk("blk_step_on", 8'(bus.rgb), 8'h6);
    cyc(3);
    chk("blk_on_end", 8'(bus.rgb), 8'h6);
    cyc(1);
    chk("blk_off2", 8'(bus.rgb), 8'h0);

    // reset in blink off phase at index 4
    bus.step_pulse = 1'b1;
    cyc(1);
    bus.step_pulse = 1'b0;
    cyc(5);
    chk("pre_rst_rgb", 8'(bus.rgb), 8'h0);
    chk("pre_rst_idx", 8'(bus.index_out), 8'h4);
    chk("pre_rst_mode", 8'(bus.mode_out), 8'h3);
    rst = 1'b0;
    bus.step_pulse = 1'b1;
    bus.mode_pulse = 1'b1;
    cyc(1);
    chk("mid_rst_rgb", 8'(bus.rgb), 8'h0);
    chk("mid_rst_mode", 8'(bus.mode_out), 8'h0);
    chk("mid_rst_idx", 8'(bus.index_out), 8'h0);
    rst = 1'b1;
    bus.step_pulse = 1'b0;
    bus.mode_pulse = 1'b0;
    cyc(1);
    chk("post_rst_mode", 8'(bus.mode_out), 8'h0);
    chk("post_rst_idx", 8'(bus.index_out), 8'h0);
    bus.step_pulse = 1'b1;
    cyc(1);
    bus.step_pulse = 1'b0;
    cyc(1);
    chk("off_step_idx", 8'(bus.index_out), 8'h0);
    chk("off_step_rgb", 8'(bus.rgb), 8'h0);
    bus.mode_pulse = 1'b1;
    cyc(1);
    bus.mode_pulse = 1'b0;
    cyc(1);
    chk("final_mode", 8'(bus.mode_out), 8'h1);
    chk("final_rgb", 8'(bus.rgb), 8'h1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
